// File: rtl/micro_sequencer.sv
// Next-address sequencer for the microprogram control store: dispatch, branch, run/halt, stall and illegal trap.
// Latency: address is combinational from the current control word; it reaches the control word one clock later.
// Backpressure: mem_busy re-issues last_q and holds it until released. MSEQ_TRACE_EN adds the ucount and br_taken outputs.
module micro_sequencer #(
    parameter int              AW         = 5,
    parameter int              OPW        = 4,
    parameter logic [AW-1:0]   START_ADDR = 5'd0,
    parameter logic [AW-1:0]   ILL_ADDR   = 5'd0,
    parameter logic [OPW-1:0]  HALT_OP    = 4'hF
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           run,
    input  logic [1:0]     nssel,
    input  logic [AW-1:0]  dbin,
    input  logic [OPW-1:0] opcode,
    input  logic           zflag,
    input  logic           mem_busy,
    output logic [AW-1:0]  address,
    output logic [1:0]     state,
    output logic           halted,
    output logic           illegal_op
`ifdef MSEQ_TRACE_EN
    ,
    output logic [15:0]    ucount,
    output logic           br_taken
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_WAIT = 2'b10,
        S_HALT = 2'b11
    } seq_state_t;

    seq_state_t    state_q, state_d;
    logic [AW-1:0] last_q;
    logic          illegal_q;
    logic          run_q;

    logic          d1_hit, d2_hit;
    logic [AW-1:0] d1_a, d2_a;
    logic          use_d1, use_d2, halt_disp, ill_disp;
    logic [AW-1:0] next_a;
    logic          advance;
    logic          illegal_set;

    always_comb begin
        d1_hit = 1'b1;
        d1_a   = '0;
        case (int'(opcode))
            0:          d1_a = AW'(15);
            1:          d1_a = AW'(16);
            2:          d1_a = AW'(17);
            3, 4, 5, 6: d1_a = AW'(1);
            7:          d1_a = AW'(9);
            8:          d1_a = AW'(19);
            9:          d1_a = AW'(21);
            default:    d1_hit = 1'b0;
        endcase
    end

    always_comb begin
        d2_hit = 1'b1;
        d2_a   = '0;
        case (int'(opcode))
            3:       d2_a = AW'(10);
            4:       d2_a = AW'(11);
            5:       d2_a = AW'(12);
            6:       d2_a = AW'(14);
            default: d2_hit = 1'b0;
        endcase
    end

    // HALT_OP is only special when reached through D1; through D2 it is an ordinary miss.
    always_comb begin
        use_d1    = (nssel == 2'b01) || ((nssel == 2'b11) && !zflag);
        use_d2    = (nssel == 2'b10);
        halt_disp = use_d1 && (opcode == HALT_OP);
        ill_disp  = !halt_disp && ((use_d1 && !d1_hit) || (use_d2 && !d2_hit));
        if (halt_disp)
            next_a = START_ADDR;
        else if (ill_disp)
            next_a = ILL_ADDR;
        else if (use_d1)
            next_a = d1_a;
        else if (use_d2)
            next_a = d2_a;
        else
            next_a = dbin;
    end

    assign advance = ((state_q == S_RUN) || (state_q == S_WAIT)) && !mem_busy;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            last_q    <= START_ADDR;
            illegal_q <= 1'b0;
            run_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= address;
            illegal_q <= illegal_q | illegal_set;
            run_q     <= run;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (run) state_d = S_RUN;
            S_RUN:  state_d = mem_busy ? S_WAIT : (halt_disp ? S_HALT : S_RUN);
            S_WAIT: if (!mem_busy) state_d = halt_disp ? S_HALT : S_RUN;
            S_HALT: if (run && !run_q) state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    // A stalled cycle re-issues last_q so the control-word register keeps its word.
    always_comb begin
        address     = START_ADDR;
        illegal_set = 1'b0;
        if (!reset) begin
            case (state_q)
                S_RUN, S_WAIT: begin
                    address     = advance ? next_a : last_q;
                    illegal_set = advance && ill_disp;
                end
                default: address = START_ADDR;
            endcase
        end
    end

    assign state      = state_q;
    assign halted     = (state_q == S_HALT);
    assign illegal_op = illegal_q;

`ifdef MSEQ_TRACE_EN
    always_ff @(posedge clock) begin
        if (reset)
            ucount <= 16'd0;
        else if ((state_q == S_RUN) && !mem_busy)
            ucount <= ucount + 16'd1;
    end

    assign br_taken = (state_q == S_RUN) && (nssel == 2'b11) && zflag;
`endif

endmodule

// File: tb/tb_micro_sequencer.sv
// Scoreboard bench for micro_sequencer: each vector pushes its expected address/state/flags and is checked at the falling edge.
module tb_micro_sequencer;

    localparam logic       L  = 1'b0;
    localparam logic       H  = 1'b1;
    localparam logic [1:0] SI = 2'b00;
    localparam logic [1:0] SR = 2'b01;
    localparam logic [1:0] SW = 2'b10;
    localparam logic [1:0] SH = 2'b11;

    logic       clock;
    logic       reset, run, zflag, mem_busy;
    logic [1:0] nssel;
    logic [4:0] dbin;
    logic [3:0] opcode;
    logic [4:0] address;
    logic [1:0] state;
    logic       halted, illegal_op;
`ifdef MSEQ_TRACE_EN
    logic [15:0] ucount;
    logic        br_taken;
    logic [15:0] uc_snap;
`endif

    micro_sequencer dut (
        .clock     (clock),
        .reset     (reset),
        .run       (run),
        .nssel     (nssel),
        .dbin      (dbin),
        .opcode    (opcode),
        .zflag     (zflag),
        .mem_busy  (mem_busy),
        .address   (address),
        .state     (state),
        .halted    (halted),
        .illegal_op(illegal_op)
`ifdef MSEQ_TRACE_EN
        ,
        .ucount    (ucount),
        .br_taken  (br_taken)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       rst, run;
        logic [1:0] ns;
        logic [4:0] db;
        logic [3:0] op;
        logic       z, mb;
        logic [4:0] a;
        logic [1:0] st;
        logic       ill;
    } vec_t;

    vec_t sb[$];
    int   tests  = 0;
    int   failed = 0;

    function automatic vec_t mk(input logic rst, input logic rn, input logic [1:0] ns,
                                input logic [4:0] db, input logic [3:0] op, input logic z,
                                input logic mb, input logic [4:0] a, input logic [1:0] st,
                                input logic ill);
        vec_t v;
        v.rst = rst; v.run = rn; v.ns = ns; v.db = db; v.op = op;
        v.z = z; v.mb = mb; v.a = a; v.st = st; v.ill = ill;
        return v;
    endfunction

    function automatic logic [4:0] d1_model(input logic [3:0] op);
        case (op)
            4'd0: return 5'd15;
            4'd1: return 5'd16;
            4'd2: return 5'd17;
            4'd7: return 5'd9;
            4'd8: return 5'd19;
            4'd9: return 5'd21;
            default: return 5'd1;
        endcase
    endfunction

    function automatic logic [4:0] d2_model(input logic [3:0] op);
        case (op)
            4'd3: return 5'd10;
            4'd4: return 5'd11;
            4'd5: return 5'd12;
            default: return 5'd14;
        endcase
    endfunction

    task automatic apply(input vec_t v);
        reset = v.rst; run = v.run; nssel = v.ns; dbin = v.db;
        opcode = v.op; zflag = v.z; mem_busy = v.mb;
        sb.push_back(v);
    endtask

    task automatic test_reset();
        vec_t q[$];
        vec_t e;
        reset = H; run = L; nssel = 2'b00; dbin = 5'd0; opcode = 4'h0; zflag = L; mem_busy = L;
        repeat (3) @(posedge clock);
        #1;
        tests++; if (state !== SI) begin failed++; $display("FAIL reset_state: got %b want %b", state, SI); end
        tests++; if (address !== 5'd0) begin failed++; $display("FAIL reset_address: got %0d want 0", address); end
        tests++; if (halted !== L) begin failed++; $display("FAIL reset_halted: got %b want 0", halted); end
        tests++; if (illegal_op !== L) begin failed++; $display("FAIL reset_illegal: got %b want 0", illegal_op); end
        q.push_back(mk(L, H, 2'b00, 5'd0, 4'h0, L, L, 5'd0, SI, L));
        q.push_back(mk(L, H, 2'b00, 5'd0, 4'h0, L, L, 5'd0, SR, L));
        foreach (q[i]) begin
            apply(q[i]);
            @(negedge clock);
            e = sb.pop_front();
            tests++;
            if (address !== e.a || state !== e.st || halted !== (e.st == SH) || illegal_op !== e.ill) begin
                failed++;
                $display("FAIL start[%0d]: address=%0d state=%b halted=%b illegal_op=%b, expected address=%0d state=%b illegal_op=%b",
                         i, address, state, halted, illegal_op, e.a, e.st, e.ill);
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_dispatch();
        vec_t q[$];
        vec_t e;
        q.push_back(mk(L, H, 2'b01, 5'd0,  4'h2, L, L, 5'd17, SR, L));
        q.push_back(mk(L, H, 2'b00, 5'd18, 4'h2, L, L, 5'd18, SR, L));
        q.push_back(mk(L, H, 2'b11, 5'd6,  4'h0, H, L, 5'd6,  SR, L));
        q.push_back(mk(L, H, 2'b11, 5'd6,  4'h7, L, L, 5'd9,  SR, L));
        q.push_back(mk(L, H, 2'b01, 5'd0,  4'h0, L, L, 5'd15, SR, L));
        q.push_back(mk(L, H, 2'b01, 5'd0,  4'h1, L, L, 5'd16, SR, L));
        q.push_back(mk(L, H, 2'b01, 5'd0,  4'h8, L, L, 5'd19, SR, L));
        q.push_back(mk(L, H, 2'b01, 5'd0,  4'h9, L, L, 5'd21, SR, L));
        q.push_back(mk(L, H, 2'b01, 5'd0,  4'h4, L, L, 5'd1,  SR, L));
        q.push_back(mk(L, H, 2'b10, 5'd0,  4'h3, L, L, 5'd10, SR, L));
        q.push_back(mk(L, H, 2'b10, 5'd0,  4'h4, L, L, 5'd11, SR, L));
        q.push_back(mk(L, H, 2'b10, 5'd0,  4'h5, L, L, 5'd12, SR, L));
        q.push_back(mk(L, H, 2'b10, 5'd0,  4'h6, L, L, 5'd14, SR, L));
        q.push_back(mk(L, H, 2'b11, 5'd31, 4'hA, H, L, 5'd31, SR, L));
        q.push_back(mk(L, L, 2'b00, 5'd0,  4'hA, L, L, 5'd0,  SR, L));
        foreach (q[i]) begin
            apply(q[i]);
            @(negedge clock);
            e = sb.pop_front();
            tests++;
            if (address !== e.a || state !== e.st || halted !== (e.st == SH) || illegal_op !== e.ill) begin
                failed++;
                $display("FAIL dispatch[%0d]: address=%0d state=%b halted=%b illegal_op=%b, expected address=%0d state=%b illegal_op=%b",
                         i, address, state, halted, illegal_op, e.a, e.st, e.ill);
            end
            @(posedge clock); #1;
        end
`ifdef MSEQ_TRACE_EN
        run = H; nssel = 2'b11; zflag = H; dbin = 5'd6; opcode = 4'h0; mem_busy = L;
        @(negedge clock);
        uc_snap = ucount;
        tests++; if (br_taken !== H) begin failed++; $display("FAIL br_taken: got %b want 1", br_taken); end
        @(posedge clock); #1;
        tests++; if (ucount !== uc_snap + 16'd1) begin failed++; $display("FAIL ucount_step: got %0d want %0d", ucount, uc_snap + 16'd1); end
        nssel = 2'b00; zflag = L; dbin = 5'd0;
        @(posedge clock); #1;
`endif
    endtask

    task automatic test_wait();
        vec_t q[$];
        vec_t e;
        q.push_back(mk(L, H, 2'b01, 5'd0, 4'h3, L, L, 5'd1,  SR, L));
        q.push_back(mk(L, H, 2'b01, 5'd0, 4'hF, L, H, 5'd1,  SR, L));
        q.push_back(mk(L, H, 2'b10, 5'd0, 4'hA, L, H, 5'd1,  SW, L));
        q.push_back(mk(L, H, 2'b00, 5'd2, 4'h0, L, H, 5'd1,  SW, L));
        q.push_back(mk(L, H, 2'b00, 5'd2, 4'h0, L, L, 5'd2,  SW, L));
        q.push_back(mk(L, H, 2'b00, 5'd7, 4'h0, L, L, 5'd7,  SR, L));
        q.push_back(mk(L, H, 2'b00, 5'd3, 4'h0, L, H, 5'd7,  SR, L));
        q.push_back(mk(L, H, 2'b01, 5'd0, 4'h8, L, L, 5'd19, SW, L));
        q.push_back(mk(L, H, 2'b00, 5'd0, 4'h0, L, L, 5'd0,  SR, L));
        foreach (q[i]) begin
            apply(q[i]);
            @(negedge clock);
            e = sb.pop_front();
            tests++;
            if (address !== e.a || state !== e.st || halted !== (e.st == SH) || illegal_op !== e.ill) begin
                failed++;
                $display("FAIL wait[%0d]: address=%0d state=%b halted=%b illegal_op=%b, expected address=%0d state=%b illegal_op=%b",
                         i, address, state, halted, illegal_op, e.a, e.st, e.ill);
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_illegal();
        vec_t q[$];
        vec_t e;
        q.push_back(mk(L, H, 2'b10, 5'd0, 4'hA, L, L, 5'd0, SR, L));
        q.push_back(mk(L, H, 2'b00, 5'd3, 4'h0, L, L, 5'd3, SR, H));
        q.push_back(mk(L, H, 2'b01, 5'd0, 4'hB, L, L, 5'd0, SR, H));
        q.push_back(mk(L, H, 2'b00, 5'd4, 4'h0, L, L, 5'd4, SR, H));
        q.push_back(mk(L, H, 2'b10, 5'd0, 4'hF, L, L, 5'd0, SR, H));
        q.push_back(mk(L, H, 2'b00, 5'd1, 4'h0, L, L, 5'd1, SR, H));
        foreach (q[i]) begin
            apply(q[i]);
            @(negedge clock);
            e = sb.pop_front();
            tests++;
            if (address !== e.a || state !== e.st || halted !== (e.st == SH) || illegal_op !== e.ill) begin
                failed++;
                $display("FAIL illegal[%0d]: address=%0d state=%b halted=%b illegal_op=%b, expected address=%0d state=%b illegal_op=%b",
                         i, address, state, halted, illegal_op, e.a, e.st, e.ill);
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_halt();
        vec_t q[$];
        vec_t e;
        q.push_back(mk(L, H, 2'b01, 5'd0,  4'hF, L, L, 5'd0,  SR, H));
        q.push_back(mk(L, H, 2'b00, 5'd5,  4'h0, L, L, 5'd0,  SH, H));
        q.push_back(mk(L, L, 2'b00, 5'd5,  4'h0, L, L, 5'd0,  SH, H));
        q.push_back(mk(L, H, 2'b00, 5'd5,  4'h0, L, L, 5'd0,  SH, H));
        q.push_back(mk(L, H, 2'b00, 5'd5,  4'h0, L, L, 5'd5,  SR, H));
        q.push_back(mk(L, H, 2'b11, 5'd6,  4'hF, L, L, 5'd0,  SR, H));
        q.push_back(mk(L, H, 2'b00, 5'd9,  4'h0, L, L, 5'd0,  SH, H));
        q.push_back(mk(L, L, 2'b00, 5'd9,  4'h0, L, L, 5'd0,  SH, H));
        q.push_back(mk(L, H, 2'b00, 5'd9,  4'h0, L, L, 5'd0,  SH, H));
        q.push_back(mk(L, H, 2'b00, 5'd12, 4'h0, L, L, 5'd12, SR, H));
        foreach (q[i]) begin
            apply(q[i]);
            @(negedge clock);
            e = sb.pop_front();
            tests++;
            if (address !== e.a || state !== e.st || halted !== (e.st == SH) || illegal_op !== e.ill) begin
                failed++;
                $display("FAIL halt[%0d]: address=%0d state=%b halted=%b illegal_op=%b, expected address=%0d state=%b illegal_op=%b",
                         i, address, state, halted, illegal_op, e.a, e.st, e.ill);
            end
            @(posedge clock); #1;
        end
        reset = L; run = H; nssel = 2'b01; opcode = 4'hF; dbin = 5'd0; zflag = L; mem_busy = L;
        @(posedge clock); #1;
        run = L; nssel = 2'b00; opcode = 4'h0;
`ifdef MSEQ_TRACE_EN
        uc_snap = ucount;
`endif
        repeat (3) @(posedge clock);
        #1;
        tests++; if (state !== SH) begin failed++; $display("FAIL halt_hold: state=%b want %b", state, SH); end
`ifdef MSEQ_TRACE_EN
        tests++; if (ucount !== uc_snap) begin failed++; $display("FAIL halt_ucount: got %0d want %0d", ucount, uc_snap); end
`endif
        run = H;
        @(posedge clock); #1;
        tests++; if (state !== SR) begin failed++; $display("FAIL halt_resume: state=%b want %b", state, SR); end
    endtask

    task automatic test_reset_mid();
        vec_t q[$];
        vec_t e;
        q.push_back(mk(H, H, 2'b00, 5'd9, 4'h0, L, L, 5'd0, SR, H));
        q.push_back(mk(L, H, 2'b00, 5'd9, 4'h0, L, L, 5'd0, SI, L));
        q.push_back(mk(L, H, 2'b00, 5'd9, 4'h0, L, L, 5'd9, SR, L));
        foreach (q[i]) begin
            apply(q[i]);
            @(negedge clock);
            e = sb.pop_front();
            tests++;
            if (address !== e.a || state !== e.st || halted !== (e.st == SH) || illegal_op !== e.ill) begin
                failed++;
                $display("FAIL reset_mid[%0d]: address=%0d state=%b halted=%b illegal_op=%b, expected address=%0d state=%b illegal_op=%b",
                         i, address, state, halted, illegal_op, e.a, e.st, e.ill);
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_back_to_back();
        vec_t       e;
        logic [1:0] ns;
        logic [4:0] db, a;
        logic [3:0] op;
        logic       z;
        for (int i = 0; i < 24; i++) begin
            ns = 2'($urandom_range(0, 3));
            z  = 1'($urandom_range(0, 1));
            db = 5'($urandom_range(0, 31));
            if (ns == 2'b10) op = 4'($urandom_range(3, 6));
            else             op = 4'($urandom_range(0, 9));
            case (ns)
                2'b00:   a = db;
                2'b01:   a = d1_model(op);
                2'b10:   a = d2_model(op);
                default: a = z ? db : d1_model(op);
            endcase
            apply(mk(L, H, ns, db, op, z, L, a, SR, L));
            @(negedge clock);
            e = sb.pop_front();
            tests++;
            if (address !== e.a || state !== e.st || halted !== (e.st == SH) || illegal_op !== e.ill) begin
                failed++;
                $display("FAIL b2b[%0d]: address=%0d state=%b halted=%b illegal_op=%b, expected address=%0d state=%b illegal_op=%b",
                         i, address, state, halted, illegal_op, e.a, e.st, e.ill);
            end
            @(posedge clock); #1;
        end
    endtask

    initial begin
        test_reset();
        test_dispatch();
        test_wait();
        test_illegal();
        test_halt();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
